// File: rtl/linebuf_pingpong_pkg.sv
// Shared definitions for the ping-pong line buffer.
//   state_t     : controller state encoding (INIT sweep, RUN)
//   *_DEF       : parameter defaults used by linebuf_pingpong and lbuf_bank
package linebuf_pingpong_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int AW_DEF    = 9;
    localparam int DW_DEF    = 8;
    localparam int TRANS_DEF = 0;
    localparam int PRIO_DEF  = 1;
    localparam int ERASE_DEF = 1;

endpackage

// File: rtl/lbuf_bank.sv
// One line-buffer bank: simple dual-port RAM, 2**AW x DW.
//   CL            : clock
//   we/wad/wdt    : write port
//   rad/rdt       : registered read port (read-first on address collision;
//                   the top level forwards colliding writes itself)
module lbuf_bank
    import linebuf_pingpong_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          CL,
    input  logic          we,
    input  logic [AW-1:0] wad,
    input  logic [DW-1:0] wdt,
    input  logic [AW-1:0] rad,
    output logic [DW-1:0] rdt
);

    logic [DW-1:0] mem [0:2**AW-1];

    always_ff @(posedge CL) begin
        if (we) mem[wad] <= wdt;
        rdt <= mem[rad];
    end

endmodule

// File: rtl/linebuf_pingpong.sv
// Ping-pong line buffer: pixels are composited into the back bank while the
// front bank is read out (and optionally erased behind the reader).
//   CL, RST         : clock, synchronous active-high reset
//   SWAP            : pulse, exchange front and back banks
//   WE/WAD/WDT      : pixel write into the back bank (read-modify-write)
//   RE/RAD          : read request from the front bank
//   RDT/RVL         : read data (held when idle) and its valid flag
//   BANK            : current front bank index
//   BUSY            : clear sweep after reset is in progress
module linebuf_pingpong
    import linebuf_pingpong_pkg::*;
#(
    parameter int            AW    = AW_DEF,
    parameter int            DW    = DW_DEF,
    parameter logic [DW-1:0] TRANS = DW'(TRANS_DEF),
    parameter int            PRIO  = PRIO_DEF,
    parameter int            ERASE = ERASE_DEF
) (
    input  logic          CL,
    input  logic          RST,
    input  logic          SWAP,
    input  logic          WE,
    input  logic [AW-1:0] WAD,
    input  logic [DW-1:0] WDT,
    input  logic          RE,
    input  logic [AW-1:0] RAD,
    output logic [DW-1:0] RDT,
    output logic          RVL,
    output logic          BANK,
    output logic          BUSY
);

    state_t        state, state_nx;
    logic [AW-1:0] cnt;
    logic          bank;
    logic          sweep, we_a, re_a, swap_a;

    // writer stage 1
    logic          w_vld, w_tag;
    logic [AW-1:0] w_ad;
    logic [DW-1:0] w_dt;
    // reader stage 1
    logic          r_vld, r_tag;
    logic [AW-1:0] r_ad;
    logic [DW-1:0] rdt_q;

    logic [1:0][DW-1:0] bank_q;   // per-bank read data, forwarding applied
    logic [DW-1:0]      stored;
    logic               w_commit, erase_v;

    // ---------------- controller ----------------
    always_ff @(posedge CL) begin
        if (RST) state <= INIT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            INIT:    if (cnt == '1) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = INIT;
        endcase
    end

    // counter wraps to 0 on the last sweep address
    always_ff @(posedge CL) begin
        if (RST)                cnt <= '0;
        else if (state == INIT) cnt <= cnt + 1'b1;
    end

    assign sweep  = (state == INIT);
    assign we_a   = WE   && !sweep;
    assign re_a   = RE   && !sweep;
    assign swap_a = SWAP && !sweep;

    // ---------------- pipelines ----------------
    // Tags capture the bank roles before any SWAP at this edge takes effect.
    always_ff @(posedge CL) begin
        if (RST) begin
            bank  <= 1'b0;
            w_vld <= 1'b0;
            w_tag <= 1'b0;
            w_ad  <= '0;
            w_dt  <= '0;
            r_vld <= 1'b0;
            r_tag <= 1'b0;
            r_ad  <= '0;
            rdt_q <= TRANS;
        end else begin
            if (swap_a) bank <= ~bank;
            w_vld <= we_a;
            w_tag <= ~bank;
            w_ad  <= WAD;
            w_dt  <= WDT;
            r_vld <= re_a;
            r_tag <= bank;
            r_ad  <= RAD;
            if (r_vld) rdt_q <= bank_q[r_tag];
        end
    end

    assign stored   = bank_q[w_tag];
    assign w_commit = w_vld && (w_dt != TRANS) && ((PRIO == 0) || (stored == TRANS));
    assign erase_v  = (ERASE != 0) && r_vld;

    // ---------------- banks ----------------
    // Writer commit and reader erase always target opposite banks (their tags
    // were front/back in the same cycle), and neither is active during the
    // sweep, so the per-bank write mux never has two live sources.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic BI = 1'(b);
        logic          we_b, hit_q;
        logic [AW-1:0] wad_b, rad_b;
        logic [DW-1:0] wdt_b, q_b, fwd_q;

        always_comb begin
            rad_b = (bank == BI) ? RAD : WAD;
            we_b  = 1'b0;
            wad_b = r_ad;
            wdt_b = TRANS;
            if (sweep) begin
                we_b  = 1'b1;
                wad_b = cnt;
            end else if (w_commit && (w_tag == BI)) begin
                we_b  = 1'b1;
                wad_b = w_ad;
                wdt_b = w_dt;
            end else if (erase_v && (r_tag == BI)) begin
                we_b  = 1'b1;
            end
        end

        lbuf_bank #(.AW(AW), .DW(DW)) u_bank (
            .CL  (CL),
            .we  (we_b),
            .wad (wad_b),
            .wdt (wdt_b),
            .rad (rad_b),
            .rdt (q_b)
        );

        // RAM is read-first: a write landing on the address being read in
        // the same cycle is substituted here so RMW and erase see it.
        always_ff @(posedge CL) begin
            if (RST) hit_q <= 1'b0;
            else     hit_q <= we_b && (wad_b == rad_b);
            fwd_q <= wdt_b;
        end

        assign bank_q[b] = hit_q ? fwd_q : q_b;
    end

    assign RDT  = r_vld ? bank_q[r_tag] : rdt_q;
    assign RVL  = r_vld;
    assign BANK = bank;
    assign BUSY = sweep;

endmodule

// File: tb/tb_linebuf_pingpong.sv
// Directed bench: two instances (PRIO=1 "p1", PRIO=0 "p0") share stimulus.
module tb_linebuf_pingpong;

    localparam int          AW = 4;
    localparam int          DW = 8;
    localparam logic [7:0]  TR = 8'h00;

    logic          CL = 1'b0;
    logic          RST, SWAP, WE, RE;
    logic [AW-1:0] WAD, RAD;
    logic [DW-1:0] WDT;
    logic [DW-1:0] rdt_p1, rdt_p0;
    logic          rvl_p1, rvl_p0, bank_p1, bank_p0, busy_p1, busy_p0;

    int checks = 0;
    int errors = 0;

    always #5 CL = ~CL;

    linebuf_pingpong #(.AW(AW), .DW(DW), .TRANS(TR), .PRIO(1), .ERASE(1)) dut_p1 (
        .CL(CL), .RST(RST), .SWAP(SWAP), .WE(WE), .WAD(WAD), .WDT(WDT),
        .RE(RE), .RAD(RAD), .RDT(rdt_p1), .RVL(rvl_p1), .BANK(bank_p1), .BUSY(busy_p1)
    );

    linebuf_pingpong #(.AW(AW), .DW(DW), .TRANS(TR), .PRIO(0), .ERASE(1)) dut_p0 (
        .CL(CL), .RST(RST), .SWAP(SWAP), .WE(WE), .WAD(WAD), .WDT(WDT),
        .RE(RE), .RAD(RAD), .RDT(rdt_p0), .RVL(rvl_p0), .BANK(bank_p0), .BUSY(busy_p0)
    );

    task automatic tick();
        @(posedge CL);
        #1;
    endtask

    task automatic do_swap();
        SWAP = 1'b1;
        tick();
        SWAP = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        RST = 1'b1; WE = 1'b0; RE = 1'b0; SWAP = 1'b0;
        WAD = '0; RAD = '0; WDT = '0;
        tick();
        RST = 1'b0;
        checks++;
        if (busy_p1 !== 1'b1 || rvl_p1 !== 1'b0 || rdt_p1 !== TR || bank_p1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b rvl=%b rdt=%h bank=%b, expected 1 0 %h 0",
                     busy_p1, rvl_p1, rdt_p1, bank_p1, TR);
        end
        n = 0;
        while (busy_p1 === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL busy_len: got %0d cycles, expected 16", n);
        end
        checks++;
        if (busy_p0 !== 1'b0) begin
            errors++;
            $display("FAIL busy_p0_done: got %b, expected 0", busy_p0);
        end
        for (int bk = 0; bk < 2; bk++) begin
            for (int a = 0; a < 16; a++) begin
                RE = 1'b1; RAD = AW'(a);
                tick();
                checks++;
                if (rvl_p1 !== 1'b1 || rdt_p1 !== TR || rvl_p0 !== 1'b1 || rdt_p0 !== TR) begin
                    errors++;
                    $display("FAIL clear_read bank%0d addr%0d: p1 %b/%h p0 %b/%h, expected 1/%h",
                             bk, a, rvl_p1, rdt_p1, rvl_p0, rdt_p0, TR);
                end
            end
            RE = 1'b0;
            if (bk == 0) begin
                do_swap();
                checks++;
                if (bank_p1 !== 1'b1) begin
                    errors++;
                    $display("FAIL swap_bank: got %b, expected 1", bank_p1);
                end
            end
        end
    endtask

    // front=1, back=0 on entry
    task automatic test_priority_erase();
        WE = 1'b1; WAD = 4'd3; WDT = 8'h05;
        tick();
        WDT = 8'h09;
        tick();
        WE = 1'b0;
        tick();
        do_swap();
        RE = 1'b1; RAD = 4'd3;
        tick();
        checks++;
        if (rvl_p1 !== 1'b1 || rdt_p1 !== 8'h05) begin
            errors++;
            $display("FAIL prio1_first_wins: got %b/%h, expected 1/05", rvl_p1, rdt_p1);
        end
        checks++;
        if (rvl_p0 !== 1'b1 || rdt_p0 !== 8'h09) begin
            errors++;
            $display("FAIL prio0_last_wins: got %b/%h, expected 1/09", rvl_p0, rdt_p0);
        end
        tick();
        checks++;
        if (rvl_p1 !== 1'b1 || rdt_p1 !== TR || rvl_p0 !== 1'b1 || rdt_p0 !== TR) begin
            errors++;
            $display("FAIL erase_second_read: p1 %b/%h p0 %b/%h, expected 1/%h",
                     rvl_p1, rdt_p1, rvl_p0, rdt_p0, TR);
        end
        RE = 1'b0;
        do_swap();
        do_swap();
        RE = 1'b1; RAD = 4'd3;
        tick();
        RE = 1'b0;
        checks++;
        if (rvl_p1 !== 1'b1 || rdt_p1 !== TR || rdt_p0 !== TR || bank_p1 !== 1'b0) begin
            errors++;
            $display("FAIL erase_after_swaps: p1 %h p0 %h bank %b, expected %h %h 0",
                     rdt_p1, rdt_p0, bank_p1, TR, TR);
        end
    endtask

    // front=0, back=1 on entry
    task automatic test_transparency();
        WE = 1'b1; WAD = 4'd10; WDT = 8'h07;
        tick();
        WDT = 8'h00;
        tick();
        WE = 1'b0;
        tick();
        do_swap();
        RE = 1'b1; RAD = 4'd10;
        tick();
        RE = 1'b0;
        checks++;
        if (rdt_p0 !== 8'h07 || rdt_p1 !== 8'h07 || rvl_p0 !== 1'b1) begin
            errors++;
            $display("FAIL transparent_skip: p0 %h p1 %h, expected 07", rdt_p0, rdt_p1);
        end
        tick();
        checks++;
        if (rvl_p0 !== 1'b0 || rdt_p0 !== 8'h07) begin
            errors++;
            $display("FAIL rdt_hold: got rvl=%b rdt=%h, expected 0/07", rvl_p0, rdt_p0);
        end
    endtask

    // front=1, back=0 on entry
    task automatic test_inflight_swap();
        WE = 1'b1; WAD = 4'd7; WDT = 8'h0A;
        tick();
        SWAP = 1'b1; WAD = 4'd5; WDT = 8'h0B;
        tick();
        SWAP = 1'b0; WE = 1'b0;
        checks++;
        if (bank_p1 !== 1'b0) begin
            errors++;
            $display("FAIL inflight_bank: got %b, expected 0", bank_p1);
        end
        RE = 1'b1; RAD = 4'd7;
        tick();
        checks++;
        if (rvl_p1 !== 1'b1 || rdt_p1 !== 8'h0A || rdt_p0 !== 8'h0A) begin
            errors++;
            $display("FAIL inflight_before_swap: p1 %h p0 %h, expected 0a", rdt_p1, rdt_p0);
        end
        RAD = 4'd5;
        tick();
        RE = 1'b0;
        checks++;
        if (rvl_p1 !== 1'b1 || rdt_p1 !== 8'h0B || rdt_p0 !== 8'h0B) begin
            errors++;
            $display("FAIL inflight_with_swap: p1 %h p0 %h, expected 0b", rdt_p1, rdt_p0);
        end
        tick();
    endtask

    task automatic test_mid_sweep_reset();
        int n;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        repeat (8) tick();
        checks++;
        if (busy_p1 !== 1'b1) begin
            errors++;
            $display("FAIL mid_sweep_busy: got %b, expected 1", busy_p1);
        end
        RST = 1'b1; WE = 1'b1; WAD = 4'd2; WDT = 8'h33;
        tick();
        RST = 1'b0;
        n = 0;
        while (busy_p1 === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        WE = 1'b0;
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL mid_sweep_len: got %0d cycles, expected 16", n);
        end
        checks++;
        if (bank_p1 !== 1'b0 || rvl_p1 !== 1'b0 || rdt_p1 !== TR) begin
            errors++;
            $display("FAIL mid_sweep_state: bank=%b rvl=%b rdt=%h, expected 0 0 %h",
                     bank_p1, rvl_p1, rdt_p1, TR);
        end
        RE = 1'b1; RAD = 4'd2;
        tick();
        RE = 1'b0;
        checks++;
        if (rvl_p1 !== 1'b1 || rdt_p1 !== TR || rdt_p0 !== TR) begin
            errors++;
            $display("FAIL busy_we_front: p1 %h p0 %h, expected %h", rdt_p1, rdt_p0, TR);
        end
        do_swap();
        RE = 1'b1; RAD = 4'd2;
        tick();
        RE = 1'b0;
        checks++;
        if (rvl_p1 !== 1'b1 || rdt_p1 !== TR || rdt_p0 !== TR) begin
            errors++;
            $display("FAIL busy_we_back: p1 %h p0 %h, expected %h", rdt_p1, rdt_p0, TR);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_priority_erase();
        test_transparency();
        test_inflight_swap();
        test_mid_sweep_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/linebuf_pingpong.md
LINEBUF_PINGPONG -- requirements
Module: linebuf_pingpong

Interface
REQ-001 SHALL have parameter AW, default 9, meaning address width; each bank holds 2**AW pixels.
REQ-002 SHALL have parameter DW, default 8, meaning pixel width.
REQ-003 SHALL have parameter TRANS, default 0, meaning the DW-bit transparent/cleared pixel value.
REQ-004 SHALL have parameter PRIO, default 1, meaning 1 = first opaque write wins, 0 = last write wins.
REQ-005 SHALL have parameter ERASE, default 1, meaning 1 = erase each pixel after it is read.
REQ-006 SHALL have port CL, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port SWAP, input, 1 bit: single-cycle pulse that exchanges the front and back banks.
REQ-009 SHALL have ports WE (input, 1 bit), WAD (input, AW bits) and WDT (input, DW bits): write strobe, address and pixel for the back bank.
REQ-010 SHALL have ports RE (input, 1 bit) and RAD (input, AW bits): read strobe and address for the front bank.
REQ-011 SHALL have ports RDT (output, DW bits) and RVL (output, 1 bit): read pixel and its valid flag.
REQ-012 SHALL have port BANK, output, 1 bit: index of the current front bank.
REQ-013 SHALL have port BUSY, output, 1 bit: high while the initial clear sweep runs.

Function
REQ-014 SHALL contain two banks of 2**AW x DW; bank BANK is front (read side) and bank ~BANK is back (write side).
REQ-015 SHALL use a state machine with states INIT and RUN; RST enters INIT.
REQ-016 In INIT, an AW-bit counter SHALL sweep addresses 0 to 2**AW-1 and write TRANS to both banks, one address per cycle.
REQ-017 SHALL enter RUN after the cycle that writes the last address; BUSY = (state == INIT).
REQ-018 In INIT, WE, RE and SWAP SHALL be ignored, and RVL SHALL stay 0.
REQ-019 In RUN, SWAP SHALL toggle BANK at the clock edge; a SWAP asserted with WE or RE in the same cycle applies the banks as they were before that edge.
REQ-020 Each write and erase operation SHALL carry a tag of the bank it was issued against and SHALL complete into that bank, even if SWAP occurs while it is in flight.
REQ-021 Writes SHALL be two-stage read-modify-write: stage 0 reads the back bank at WAD; stage 1 decides and commits.
REQ-022 In stage 1, a WDT equal to TRANS SHALL never be written.
REQ-023 In stage 1 with PRIO=1, the write SHALL commit only if the stored pixel equals TRANS.
REQ-024 In stage 1 with PRIO=0, every opaque pixel SHALL commit.
REQ-025 Stage 1 SHALL forward a committed value to a stage-0 access of the same address and bank in the next cycle; back-to-back writes to one address SHALL behave as if sequential.
REQ-026 Reads: RE at cycle n SHALL present front[RAD] on RDT with RVL=1 at cycle n+1.
REQ-027 When no read issued at cycle n, RVL SHALL be 0 at n+1 and RDT SHALL hold its last value.
REQ-028 With ERASE=1, the read location SHALL be written with TRANS in cycle n+1, in the bank tagged at cycle n.
REQ-029 Consecutive reads of the same address SHALL return the first value, then TRANS; erase is forwarded.
REQ-030 Full-throughput WE and RE SHALL be accepted every cycle; there is no backpressure in RUN.

Reset
REQ-031 On RST, the outputs SHALL be RDT=TRANS, RVL=0, BANK=0 and BUSY=1, with pipeline valid bits and the sweep counter at 0.
REQ-032 RST asserted mid-sweep or mid-pipeline SHALL discard in-flight operations and restart the sweep at address 0.
REQ-033 RAM contents SHALL only be initialised by the sweep, never by reset logic.

Structure
REQ-034 A shared package SHALL hold the state encoding (INIT, RUN) and the parameter defaults.
REQ-035 Each bank SHALL be one instance of sub-module lbuf_bank: a simple dual-port RAM with one registered read port and one write port on CL, inferable as block RAM.
REQ-036 Per bank, the write port SHALL be muxed between the sweep, writer stage 1 and reader erase; these SHALL never conflict, by bank tag.

Verification
REQ-037 Bench SHALL check reset: RST 1 cycle, AW=4 -> BUSY=1 for 16 cycles, then 0; all reads of both banks after a swap return TRANS.
REQ-038 Bench SHALL check priority: PRIO=1, write 0x05 then 0x09 to address 3, SWAP, read 3 -> 0x05; the same with PRIO=0 -> 0x09.
REQ-039 Bench SHALL check transparency: write 0x00 over 0x07 at address 10 (PRIO=0) -> read returns 0x07.
REQ-040 Bench SHALL check erase: after SWAP, read address 3 on two consecutive cycles -> 0x05 with RVL=1, then TRANS; a second SWAP pair then reads TRANS.
REQ-041 Bench SHALL check the in-flight swap: WE to address 7 with 0x0A in the cycle before SWAP -> the value lands in the old back bank, now front, and the read returns 0x0A.
REQ-042 Bench SHALL check mid-sweep reset: RST at sweep address 8 -> BUSY stays 1 for 16 more cycles; WE during BUSY has no effect.
